tile_board_ctrl: RTL and testbench



---
 rtl/tile_board_pkg.sv | 26 ++
 rtl/tile_board_ctrl_tile_store.sv | 51 +++++
 rtl/tile_board_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_tile_board_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_board_pkg.sv
// tile_board_pkg
//   Shared encodings for the tile-map board controller: background colour
//   index codes, CTRL register bit positions and the clear-sweep FSM states.
package tile_board_pkg;

  localparam logic [1:0] BG_CHECK0 = 2'b00;
  localparam logic [1:0] BG_CHECK1 = 2'b01;
  localparam logic [1:0] BG_HILITE = 2'b10;
  localparam logic [1:0] BG_CURSOR = 2'b11;

  // CTRL: write bit0 starts a clear; read bit0 = busy, bit1 = blink phase
  localparam int CTRL_CLEAR_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 0;
  localparam int CTRL_PHASE_BIT = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Index width that stays legal for a single-entry range
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tile_board_ctrl_tile_store.sv
// tile_store
//   NT x DW tile entry array. One write port (the caller muxes clear sweep
//   and Avalon), plus two independent registered read ports: one for the
//   video pipeline, one for Avalon reads (which holds until the next read).
//   The array itself is not reset; only the read registers are.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_we/i_waddr/i_wdata    write port
//   i_vid_addr/o_vid_data   video read port, one cycle latency, every cycle
//   i_avl_re/i_avl_addr     Avalon read strobe and address
//   o_avl_data              Avalon read data, held between reads
module tile_store #(
  parameter int NT = 64,
  parameter int DW = 6,
  parameter int TW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [TW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [TW-1:0] i_vid_addr,
  output logic [DW-1:0] o_vid_data,
  input  logic          i_avl_re,
  input  logic [TW-1:0] i_avl_addr,
  output logic [DW-1:0] o_avl_data
);

  logic [DW-1:0] r_mem [NT];
  logic [DW-1:0] r_vid_data;
  logic [DW-1:0] r_avl_data;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Reads see the pre-write contents on a same-cycle collision
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vid_data <= '0;
      r_avl_data <= '0;
    end else begin
      r_vid_data <= r_mem[i_vid_addr];
      if (i_avl_re) r_avl_data <= r_mem[i_avl_addr];
    end
  end

  assign o_vid_data = r_vid_data;
  assign o_avl_data = r_avl_data;

endmodule

// File: rtl/tile_board_ctrl.sv
// tile_board_ctrl
//   Tile-map board controller for the VGA path. Holds a BOARD_W x BOARD_H
//   tile store (image index, highlight, blink), exposes it on an Avalon-MM
//   slave, and turns DrawX/DrawY into sprite pixel address, image index,
//   on-board flag and background colour index with a fixed 2-cycle latency.
//   Includes a hardware clear sweep (also run out of reset) and frame-based
//   highlight blinking.
// Optional feature macro: TILE_CURSOR_EN (cursor register at NT+1).
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   DrawX, DrawY          current pixel column/row
//   AVL_*                 Avalon-MM slave, read latency 1
//   pixel_addr            offset inside the tile sprite
//   img_addr              image index of the current tile
//   board_on              pixel lies on the board
//   background_index      00/01 checker, 10 highlight, 11 cursor
//
// Clear FSM:
//   state    | meaning
//   ST_IDLE  | normal operation, Avalon tile writes accepted
//   ST_CLEAR | zeroing entry idx each cycle, Avalon tile writes dropped
module tile_board_ctrl
  import tile_board_pkg::*;
#(
  parameter int BOARD_W      = 8,
  parameter int BOARD_H      = 8,
  parameter int TILE_PX      = 60,
  parameter int IMG_BITS     = 4,
  parameter int X_ORIGIN     = 0,
  parameter int Y_ORIGIN     = 0,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                                       CLK,
  input  logic                                       RESET_N,
  input  logic [9:0]                                 DrawX,
  input  logic [9:0]                                 DrawY,
  input  logic                                       AVL_READ,
  input  logic                                       AVL_WRITE,
  input  logic                                       AVL_CS,
  input  logic [$clog2(BOARD_W*BOARD_H+2)-1:0]       AVL_ADDR,
  input  logic [7:0]                                 AVL_WRITEDATA,
  output logic [7:0]                                 AVL_READDATA,
  output logic [$clog2(TILE_PX*TILE_PX)-1:0]         pixel_addr,
  output logic [IMG_BITS-1:0]                        img_addr,
  output logic                                       board_on,
  output logic [1:0]                                 background_index
);

  localparam int NT  = BOARD_W * BOARD_H;
  localparam int AW  = $clog2(NT + 2);
  localparam int PA  = $clog2(TILE_PX * TILE_PX);
  localparam int DW  = IMG_BITS + 2;
  localparam int TW  = clog2_min1(NT);
  localparam int CW  = clog2_min1(BOARD_W);
  localparam int RW  = clog2_min1(BOARD_H);
  localparam int OW  = clog2_min1(TILE_PX);
  localparam int BFW = clog2_min1(BLINK_FRAMES);

  // Avalon decode
  logic w_avl_wr, w_avl_rd;
  logic w_addr_tile, w_addr_ctrl, w_addr_cursor;

  assign w_avl_wr      = AVL_CS && AVL_WRITE;
  assign w_avl_rd      = AVL_CS && AVL_READ;
  assign w_addr_tile   = AVL_ADDR < AW'(NT);
  assign w_addr_ctrl   = AVL_ADDR == AW'(NT);
  assign w_addr_cursor = AVL_ADDR == AW'(NT + 1);

  // Clear sweep FSM
  clr_state_t    r_state, w_state_nxt;
  logic [TW-1:0] r_clr_idx, w_clr_idx_nxt;
  logic          w_st_we;
  logic [TW-1:0] w_st_waddr;
  logic [DW-1:0] w_st_wdata;
  logic          w_busy;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_st_we       = 1'b0;
    w_st_waddr    = TW'(AVL_ADDR);
    w_st_wdata    = AVL_WRITEDATA[DW-1:0];
    case (r_state)
      ST_IDLE: begin
        if (w_avl_wr && w_addr_tile) w_st_we = 1'b1;
        if (w_avl_wr && w_addr_ctrl && AVL_WRITEDATA[CTRL_CLEAR_BIT]) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      ST_CLEAR: begin
        w_st_we    = 1'b1;
        w_st_waddr = r_clr_idx;
        w_st_wdata = '0;
        if (r_clr_idx == TW'(NT - 1)) w_state_nxt = ST_IDLE;
        else                          w_clr_idx_nxt = r_clr_idx + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);

  // S1: board-relative position. 12-bit subtraction so that a pixel left of
  // (or above) the origin wraps far past any legal board extent.
  logic [11:0] w_dx, w_dy;
  logic        w_on;

  assign w_dx = {2'b00, DrawX} - 12'(X_ORIGIN);
  assign w_dy = {2'b00, DrawY} - 12'(Y_ORIGIN);
  assign w_on = (w_dx < 12'(BOARD_W * TILE_PX)) && (w_dy < 12'(BOARD_H * TILE_PX));

  logic          r_s1_on;
  logic [CW-1:0] r_s1_col;
  logic [RW-1:0] r_s1_row;
  logic [OW-1:0] r_s1_offx, r_s1_offy;
  logic [9:0]    r_s1_x, r_s1_y;
  logic          w_frame_tick;

  // A new frame is seen when S1 is about to load (0,0) from any other value
  assign w_frame_tick = (DrawX == 10'd0) && (DrawY == 10'd0) &&
                        ((r_s1_x != 10'd0) || (r_s1_y != 10'd0));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_on   <= 1'b0;
      r_s1_col  <= '0;
      r_s1_row  <= '0;
      r_s1_offx <= '0;
      r_s1_offy <= '0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
    end else begin
      r_s1_on   <= w_on;
      r_s1_col  <= w_on ? CW'(w_dx / 12'(TILE_PX)) : '0;
      r_s1_row  <= w_on ? RW'(w_dy / 12'(TILE_PX)) : '0;
      r_s1_offx <= w_on ? OW'(w_dx % 12'(TILE_PX)) : '0;
      r_s1_offy <= w_on ? OW'(w_dy % 12'(TILE_PX)) : '0;
      r_s1_x    <= DrawX;
      r_s1_y    <= DrawY;
    end
  end

  // Blink phase
  logic [BFW-1:0] r_frame_cnt;
  logic           r_blink_phase;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_tick) begin
      if (r_frame_cnt == BFW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Cursor
  logic [TW-1:0] w_s1_tile;
  logic          w_cur_match;

  assign w_s1_tile = TW'(int'(r_s1_row) * BOARD_W + int'(r_s1_col));

`ifdef TILE_CURSOR_EN
  localparam int CURSOR_EN_BIT = 7;
  logic [7:0] r_cursor;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                       r_cursor <= '0;
    else if (w_avl_wr && w_addr_cursor) r_cursor <= AVL_WRITEDATA;
  end

  // An index at or beyond NT can never equal a real tile number
  assign w_cur_match = r_cursor[CURSOR_EN_BIT] &&
                       (int'(r_cursor[6:0]) == int'(w_s1_tile));
`else
  assign w_cur_match = 1'b0;
`endif

  // S2: the store's registered video read port lines up with these registers
  logic          r_s2_on;
  logic [PA-1:0] r_s2_pix;
  logic          r_s2_chk;
  logic          r_s2_cur;
  logic [DW-1:0] w_vid_entry;
  logic [DW-1:0] w_avl_entry;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s2_on  <= 1'b0;
      r_s2_pix <= '0;
      r_s2_chk <= 1'b0;
      r_s2_cur <= 1'b0;
    end else begin
      r_s2_on  <= r_s1_on;
      r_s2_pix <= r_s1_on ? PA'(int'(r_s1_offy) * TILE_PX + int'(r_s1_offx)) : '0;
      r_s2_chk <= r_s1_on && (r_s1_col[0] ^ r_s1_row[0]);
      r_s2_cur <= r_s1_on && w_cur_match;
    end
  end

  tile_store #(
    .NT (NT),
    .DW (DW),
    .TW (TW)
  ) u_store (
    .i_clk      (CLK),
    .i_rst_n    (RESET_N),
    .i_we       (w_st_we),
    .i_waddr    (w_st_waddr),
    .i_wdata    (w_st_wdata),
    .i_vid_addr (w_s1_tile),
    .o_vid_data (w_vid_entry),
    .i_avl_re   (w_avl_rd && w_addr_tile),
    .i_avl_addr (TW'(AVL_ADDR)),
    .o_avl_data (w_avl_entry)
  );

  logic w_hilite, w_blink;

  assign w_hilite = w_vid_entry[IMG_BITS];
  assign w_blink  = w_vid_entry[IMG_BITS + 1];

  assign board_on   = r_s2_on;
  assign pixel_addr = r_s2_pix;
  assign img_addr   = r_s2_on ? w_vid_entry[IMG_BITS-1:0] : '0;

  always_comb begin
    background_index = BG_CHECK0;
    if (r_s2_on) begin
      if (r_s2_cur)                                  background_index = BG_CURSOR;
      else if (w_hilite && (!w_blink || r_blink_phase)) background_index = BG_HILITE;
      else                                           background_index = r_s2_chk ? BG_CHECK1 : BG_CHECK0;
    end
  end

  // Avalon read data: tile reads come from the store's held read register,
  // everything else from r_rd_misc captured at the same edge.
  logic       r_rd_tile;
  logic [7:0] r_rd_misc;
  logic [7:0] w_misc_rdata;

  always_comb begin
    w_misc_rdata = '0;
    if (w_addr_ctrl) begin
      w_misc_rdata[CTRL_BUSY_BIT]  = w_busy;
      w_misc_rdata[CTRL_PHASE_BIT] = r_blink_phase;
    end
`ifdef TILE_CURSOR_EN
    if (w_addr_cursor) w_misc_rdata = r_cursor;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rd_tile <= 1'b0;
      r_rd_misc <= '0;
    end else if (w_avl_rd) begin
      r_rd_tile <= w_addr_tile;
      r_rd_misc <= w_misc_rdata;
    end
  end

  assign AVL_READDATA = r_rd_tile ? 8'(w_avl_entry) : r_rd_misc;

  logic w_unused;
  assign w_unused = &{1'b0, AVL_WRITEDATA, w_addr_cursor};

endmodule

// File: tb/tb_tile_board_ctrl.sv
module tb_tile_board_ctrl;

  localparam int BW = 8;
  localparam int BH = 8;
  localparam int TP = 60;
  localparam int NT = BW * BH;
  localparam int AW = $clog2(NT + 2);
  localparam int PA = $clog2(TP * TP);
  localparam int BLINK_FRAMES = 2;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [9:0]    DrawX = '0;
  logic [9:0]    DrawY = '0;
  logic          AVL_READ = 1'b0;
  logic          AVL_WRITE = 1'b0;
  logic          AVL_CS = 1'b0;
  logic [AW-1:0] AVL_ADDR = '0;
  logic [7:0]    AVL_WRITEDATA = '0;
  logic [7:0]    AVL_READDATA;
  logic [PA-1:0] pixel_addr;
  logic [3:0]    img_addr;
  logic          board_on;
  logic [1:0]    background_index;

  tile_board_ctrl #(
    .BOARD_W      (BW),
    .BOARD_H      (BH),
    .TILE_PX      (TP),
    .IMG_BITS     (4),
    .X_ORIGIN     (0),
    .Y_ORIGIN     (0),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .DrawX            (DrawX),
    .DrawY            (DrawY),
    .AVL_READ         (AVL_READ),
    .AVL_WRITE        (AVL_WRITE),
    .AVL_CS           (AVL_CS),
    .AVL_ADDR         (AVL_ADDR),
    .AVL_WRITEDATA    (AVL_WRITEDATA),
    .AVL_READDATA     (AVL_READDATA),
    .pixel_addr       (pixel_addr),
    .img_addr         (img_addr),
    .board_on         (board_on),
    .background_index (background_index)
  );

  always #5 CLK = ~CLK;

  // scoreboard
  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  // reference model
  logic [7:0] m_mem [NT];
  logic [7:0] m_cursor = 8'h00;
  logic       m_phase  = 1'b0;
  int         m_cnt    = 0;
  int         m_last_x = 0;
  int         m_last_y = 0;

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic avl_wr(input int a, input logic [7:0] d);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(a); AVL_WRITEDATA = d;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic tile_wr(input int t, input logic [7:0] d);
    avl_wr(t, d);
    m_mem[t] = d & 8'h3F;
  endtask

  task automatic avl_rd(input int a, input logic [7:0] exp, input string nm);
    sb_push(nm, {24'b0, exp});
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = AW'(a);
    tick();
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    sb_check({24'b0, AVL_READDATA});
  endtask

  // read and write the same tile in one cycle: read returns the old value
  task automatic avl_rw(input int a, input logic [7:0] d, input logic [7:0] exp_old, input string nm);
    sb_push(nm, {24'b0, exp_old});
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = AW'(a); AVL_WRITEDATA = d;
    tick();
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    m_mem[a] = d & 8'h3F;
    sb_check({24'b0, AVL_READDATA});
  endtask

  function automatic logic [7:0] ctrl_idle();
    return {6'b0, m_phase, 1'b0};
  endfunction

  task automatic pix_check(input int x, input int y, input string nm);
    int on, col, row, t, pa, img, bg;
    logic [7:0] e;
    if (x == 0 && y == 0 && (m_last_x != 0 || m_last_y != 0)) begin
      m_cnt++;
      if (m_cnt == BLINK_FRAMES) begin
        m_cnt = 0;
        m_phase = ~m_phase;
      end
    end
    m_last_x = x;
    m_last_y = y;
    on = (x < BW * TP && y < BH * TP) ? 1 : 0;
    pa = 0; img = 0; bg = 0;
    if (on != 0) begin
      col = x / TP;
      row = y / TP;
      t   = row * BW + col;
      e   = m_mem[t];
      pa  = (y % TP) * TP + (x % TP);
      img = int'(e[3:0]);
      if (m_cursor[7] && int'(m_cursor[6:0]) == t) bg = 3;
      else if (e[4] && (!e[5] || m_phase)) bg = 2;
      else bg = (col ^ row) & 1;
    end
    sb_push({nm, ".board_on"}, 32'(on));
    sb_push({nm, ".pixel_addr"}, 32'(pa));
    sb_push({nm, ".img_addr"}, 32'(img));
    sb_push({nm, ".bg"}, 32'(bg));
    DrawX = 10'(x);
    DrawY = 10'(y);
    tick();
    tick();
    sb_check({31'b0, board_on});
    sb_check({20'b0, pixel_addr});
    sb_check({28'b0, img_addr});
    sb_check({30'b0, background_index});
  endtask

  task automatic check_outputs_zero(input string nm);
    sb_push({nm, ".readdata"}, 32'd0);
    sb_push({nm, ".board_on"}, 32'd0);
    sb_push({nm, ".pixel_addr"}, 32'd0);
    sb_push({nm, ".img_addr"}, 32'd0);
    sb_push({nm, ".bg"}, 32'd0);
    sb_check({24'b0, AVL_READDATA});
    sb_check({31'b0, board_on});
    sb_check({20'b0, pixel_addr});
    sb_check({28'b0, img_addr});
    sb_check({30'b0, background_index});
  endtask

  // Counts cycles with busy high, polling CTRL every cycle; on inj_cyc a
  // write is issued instead of a poll and counted as a busy cycle.
  task automatic measure_busy(input string nm, input int inj_cyc, input int inj_addr,
                              input logic [7:0] inj_data);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    sb_push(nm, 32'd64);
    for (int c = 1; c <= 200 && !done; c++) begin
      if (c == inj_cyc) begin
        avl_wr(inj_addr, inj_data);
        n++;
      end else begin
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = AW'(NT);
        tick();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        if (AVL_READDATA[0] === 1'b1) n++;
        else done = 1'b1;
      end
    end
    if (!done) n = -1;
    sb_check(32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NT; i++) m_mem[i] = 8'h00;

    // reset values
    repeat (3) tick();
    check_outputs_zero("reset");

    // sweep out of reset; tile-5 write at cycle 10 must be dropped
    RESET_N = 1'b1;
    measure_busy("busy_after_reset", 10, 5, 8'h03);
    avl_rd(5, 8'h00, "t5_dropped");
    tile_wr(5, 8'h03);
    avl_rd(5, 8'h03, "t5_readback");
    tile_wr(6, 8'hFF);
    avl_rd(6, 8'h3F, "t6_upper_bits");
    avl_rw(6, 8'h01, 8'h3F, "t6_rw_old");
    avl_rd(6, 8'h01, "t6_rw_new");
    avl_wr(100, 8'hFF);
    avl_rd(100, 8'h00, "unmapped");
    avl_rd(NT, ctrl_idle(), "ctrl_idle");

    // video mapping
    tile_wr(9, 8'h17);
    pix_check(75, 70, "t9");
    pix_check(485, 70, "off_x");
    pix_check(70, 485, "off_y");
    pix_check(479, 479, "corner");
    pix_check(60, 0, "t1_checker");

    // blink
    tile_wr(0, 8'h30);
    for (int f = 0; f < 4; f++) begin
      pix_check(1, 0, "blink_pre");
      pix_check(0, 0, "blink_frame");
      avl_rd(NT, ctrl_idle(), "ctrl_phase");
    end

    // cursor
`ifdef TILE_CURSOR_EN
    avl_wr(NT + 1, 8'h89);
    m_cursor = 8'h89;
    avl_rd(NT + 1, 8'h89, "cursor_rd");
    pix_check(75, 70, "cursor_t9");
    pix_check(135, 70, "cursor_t10");
    avl_wr(NT + 1, 8'hC8);
    m_cursor = 8'hC8;
    pix_check(75, 70, "cursor72_t9");
    pix_check(479, 479, "cursor72_corner");
    avl_wr(NT + 1, 8'h00);
    m_cursor = 8'h00;
`else
    avl_wr(NT + 1, 8'h89);
    avl_rd(NT + 1, 8'h00, "cursor_absent");
    pix_check(75, 70, "nocursor_t9");
`endif

    // software clear with a second CTRL write mid-sweep
    tile_wr(20, 8'h2A);
    tile_wr(63, 8'h15);
    avl_wr(NT, 8'h02);
    avl_rd(NT, ctrl_idle(), "ctrl_bit1_only");
    avl_wr(NT, 8'h01);
    measure_busy("busy_clear", 20, NT, 8'h01);
    for (int i = 0; i < NT; i++) m_mem[i] = 8'h00;
    for (int i = 0; i < NT; i++) avl_rd(i, 8'h00, "cleared");
    pix_check(479, 479, "cleared_corner");

    // reset in the middle of a sweep (idx 30)
    tile_wr(9, 8'h17);
    pix_check(75, 70, "pre_reset_t9");
    avl_wr(NT, 8'h01);
    repeat (29) tick();
    avl_rd(NT, {6'b0, m_phase, 1'b1}, "busy_mid");
    RESET_N = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    DrawX = '0;
    DrawY = '0;
    m_phase = 1'b0;
    m_cnt = 0;
    m_last_x = 0;
    m_last_y = 0;
    repeat (2) tick();
    RESET_N = 1'b1;
    measure_busy("busy_restart", 0, 0, 8'h00);
    for (int i = 0; i < NT; i++) m_mem[i] = 8'h00;
    pix_check(75, 70, "post_reset_t9");
    avl_rd(9, 8'h00, "post_reset_t9_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
